// File: rtl/priority_encoder_scan_if.sv
// Request/beat bundle for priority_encoder_scan: vector-in handshake plus index-out handshake.
// master = producer of vectors / consumer of beats; slave = the encoder itself.
interface priority_encoder_scan_if #(
    parameter int WIDTH = 8
);
    localparam int IDX_W = $clog2(WIDTH);

    logic [WIDTH-1:0] in_vec;
    logic             in_scan;
    logic             in_valid;
    logic             in_ready;
    logic [IDX_W-1:0] out_idx;
    logic             out_zero;
    logic             out_last;
    logic [IDX_W:0]   out_count;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_vec, in_scan, in_valid, out_ready,
        input  in_ready, out_idx, out_zero, out_last, out_count, out_valid
    );

    modport slave (
        input  in_vec, in_scan, in_valid, out_ready,
        output in_ready, out_idx, out_zero, out_last, out_count, out_valid
    );
endinterface

// File: rtl/priority_encoder_scan.sv
// Sequential priority encoder: accepts a request vector, then emits either the top-priority
// index (single mode) or every set bit in priority order (scan mode), one beat per transfer.
module priority_encoder_scan #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic                   clk,
    input logic                   rst,
    priority_encoder_scan_if.slave bus
);
    localparam int IDX_W = $clog2(WIDTH);
    localparam int CNT_W = IDX_W + 1;

    typedef enum logic {
        IDLE,
        EMIT
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             zero_q, zero_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [IDX_W-1:0] head_idx, in_head_idx;
    logic [WIDTH-1:0] head_bit, in_head_bit;
    logic             head_single;
    logic             emit_last;

    logic             in_ready;
    logic             out_valid;
    logic [IDX_W-1:0] out_idx;
    logic             out_zero;
    logic             out_last;
    logic [CNT_W-1:0] out_count;

    // Scans the whole vector so the highest-priority set bit wins; only real bits are visited.
    function automatic logic [IDX_W-1:0] first_idx(input logic [WIDTH-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (MSB_FIRST) begin
                if (v[i]) idx = IDX_W'(i);
            end else begin
                if (v[WIDTH-1-i]) idx = IDX_W'(WIDTH-1-i);
            end
        end
        return idx;
    endfunction

    function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    always_comb begin
        head_idx    = first_idx(pend_q);
        head_bit    = WIDTH'(1) << head_idx;
        in_head_idx = first_idx(bus.in_vec);
        in_head_bit = WIDTH'(1) << in_head_idx;
        head_single = (pend_q != '0) && ((pend_q & (pend_q - WIDTH'(1))) == '0);
        emit_last   = zero_q | head_single;
    end

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        zero_d    = zero_q;
        count_d   = count_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_idx   = '0;
        out_zero  = 1'b0;
        out_last  = 1'b0;
        out_count = '0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    zero_d  = (bus.in_vec == '0);
                    state_d = EMIT;
                    if (bus.in_scan) begin
                        pend_d  = bus.in_vec;
                        count_d = (bus.in_vec == '0) ? CNT_W'(1) : popcount(bus.in_vec);
                    end else begin
                        // Masking with in_vec keeps a zero vector's pending set empty.
                        pend_d  = in_head_bit & bus.in_vec;
                        count_d = CNT_W'(1);
                    end
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                out_idx   = head_idx;
                out_zero  = zero_q;
                out_last  = emit_last;
                out_count = count_q;
                if (bus.out_ready) begin
                    pend_d = pend_q & ~head_bit;
                    if (emit_last) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            zero_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            zero_q  <= zero_d;
            count_q <= count_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_idx   = out_idx;
    assign bus.out_zero  = out_zero;
    assign bus.out_last  = out_last;
    assign bus.out_count = out_count;
endmodule

// File: tb/tb_priority_encoder_scan.sv
// Scoreboard bench for priority_encoder_scan: three instances (8/MSB, 8/LSB, 5/MSB),
// directed vectors push hand-computed beats; per-instance monitors pop and compare.
module tb_priority_encoder_scan;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    priority_encoder_scan_if #(.WIDTH(8)) ifa ();
    priority_encoder_scan_if #(.WIDTH(8)) ifb ();
    priority_encoder_scan_if #(.WIDTH(5)) ifc ();

    priority_encoder_scan #(.WIDTH(8), .MSB_FIRST(1'b1)) u_a (.clk(clk), .rst(rst), .bus(ifa));
    priority_encoder_scan #(.WIDTH(8), .MSB_FIRST(1'b0)) u_b (.clk(clk), .rst(rst), .bus(ifb));
    priority_encoder_scan #(.WIDTH(5), .MSB_FIRST(1'b1)) u_c (.clk(clk), .rst(rst), .bus(ifc));

    typedef struct {
        int idx;
        int zero;
        int last;
        int count;
    } beat_t;

    beat_t qa[$];
    beat_t qb[$];
    beat_t qc[$];
    int checks   = 0;
    int failures = 0;
    int beats_a  = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic beat_t mk(input int i, input int z, input int l, input int c);
        beat_t b;
        b.idx = i; b.zero = z; b.last = l; b.count = c;
        return b;
    endfunction

    task automatic cmp_beat(input string p, input beat_t act, input beat_t exp);
        check({p, "_idx"},   act.idx,   exp.idx);
        check({p, "_zero"},  act.zero,  exp.zero);
        check({p, "_last"},  act.last,  exp.last);
        check({p, "_count"}, act.count, exp.count);
    endtask

    task automatic unexpected(input string p, input beat_t act);
        checks++;
        failures++;
        $display("FAIL %s_unexpected_beat actual_idx=%0d expected=no_beat", p, act.idx);
    endtask

    // Monitor A: also checks that a stalled beat keeps all fields stable.
    initial begin : mon_a
        beat_t cur, prev, e;
        logic  stall;
        stall = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && ifa.out_valid) begin
                cur = mk(int'(ifa.out_idx), int'(ifa.out_zero), int'(ifa.out_last), int'(ifa.out_count));
                check("a_idx_range", (cur.idx < 8) ? 1 : 0, 1);
                if (stall) cmp_beat("a_hold", cur, prev);
                prev  = cur;
                stall = !ifa.out_ready;
                if (ifa.out_ready) begin
                    if (qa.size() == 0) unexpected("a", cur);
                    else begin
                        e = qa.pop_front();
                        cmp_beat("a_beat", cur, e);
                    end
                    beats_a++;
                end
            end else begin
                stall = 1'b0;
            end
        end
    end

    initial begin : mon_b
        beat_t cur, e;
        forever begin
            @(negedge clk);
            if (!rst && ifb.out_valid && ifb.out_ready) begin
                cur = mk(int'(ifb.out_idx), int'(ifb.out_zero), int'(ifb.out_last), int'(ifb.out_count));
                if (qb.size() == 0) unexpected("b", cur);
                else begin
                    e = qb.pop_front();
                    cmp_beat("b_beat", cur, e);
                end
            end
        end
    end

    initial begin : mon_c
        beat_t cur, e;
        forever begin
            @(negedge clk);
            if (!rst && ifc.out_valid && ifc.out_ready) begin
                cur = mk(int'(ifc.out_idx), int'(ifc.out_zero), int'(ifc.out_last), int'(ifc.out_count));
                check("c_idx_range", (cur.idx < 5) ? 1 : 0, 1);
                if (qc.size() == 0) unexpected("c", cur);
                else begin
                    e = qc.pop_front();
                    cmp_beat("c_beat", cur, e);
                end
            end
        end
    end

    task automatic send_a(input logic [7:0] v, input logic s);
        int n = 0;
        while (!ifa.in_ready && n < 50) begin @(posedge clk); #1; n++; end
        check("a_accept_ready", int'(ifa.in_ready), 1);
        ifa.in_vec = v; ifa.in_scan = s; ifa.in_valid = 1'b1;
        @(posedge clk); #1;
        ifa.in_valid = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] v, input logic s);
        int n = 0;
        while (!ifb.in_ready && n < 50) begin @(posedge clk); #1; n++; end
        check("b_accept_ready", int'(ifb.in_ready), 1);
        ifb.in_vec = v; ifb.in_scan = s; ifb.in_valid = 1'b1;
        @(posedge clk); #1;
        ifb.in_valid = 1'b0;
    endtask

    task automatic send_c(input logic [4:0] v, input logic s);
        int n = 0;
        while (!ifc.in_ready && n < 50) begin @(posedge clk); #1; n++; end
        check("c_accept_ready", int'(ifc.in_ready), 1);
        ifc.in_vec = v; ifc.in_scan = s; ifc.in_valid = 1'b1;
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
    endtask

    task automatic wait_empty();
        int n = 0;
        while ((qa.size() + qb.size() + qc.size()) != 0 && n < 200) begin @(posedge clk); #1; n++; end
        check("drain_a", qa.size(), 0);
        check("drain_b", qb.size(), 0);
        check("drain_c", qc.size(), 0);
    endtask

    initial begin : stim
        int base;
        int n;
        rst = 1'b1;
        ifa.in_vec = '0; ifa.in_scan = 1'b0; ifa.in_valid = 1'b0; ifa.out_ready = 1'b1;
        ifb.in_vec = '0; ifb.in_scan = 1'b0; ifb.in_valid = 1'b0; ifb.out_ready = 1'b1;
        ifc.in_vec = '0; ifc.in_scan = 1'b0; ifc.in_valid = 1'b0; ifc.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_out_valid", int'(ifa.out_valid), 0);
        check("rst_in_ready",  int'(ifa.in_ready),  1);
        check("rst_out_count", int'(ifa.out_count), 0);
        check("rst_out_idx",   int'(ifa.out_idx),   0);
        check("rst_out_last",  int'(ifa.out_last),  0);
        check("rst_out_zero",  int'(ifa.out_zero),  0);

        // Scan 1010_0100, MSB first: 7, 5, 2 back to back
        qa.push_back(mk(7, 0, 0, 3));
        qa.push_back(mk(5, 0, 0, 3));
        qa.push_back(mk(2, 0, 1, 3));
        send_a(8'b1010_0100, 1'b1);
        check("t1_busy_in_ready", int'(ifa.in_ready), 0);
        check("t1_first_valid",   int'(ifa.out_valid), 1);
        repeat (3) @(posedge clk);
        #1;
        check("t1_ready_after_last", int'(ifa.in_ready),  1);
        check("t1_idle_out_valid",   int'(ifa.out_valid), 0);

        // LSB-first and non-power-of-two instances
        qb.push_back(mk(2, 0, 0, 3));
        qb.push_back(mk(5, 0, 0, 3));
        qb.push_back(mk(7, 0, 1, 3));
        send_b(8'b1010_0100, 1'b1);
        qc.push_back(mk(4, 0, 0, 3));
        qc.push_back(mk(1, 0, 0, 3));
        qc.push_back(mk(0, 0, 1, 3));
        send_c(5'b10011, 1'b1);
        wait_empty();

        // Single mode, then zero vector
        qa.push_back(mk(7, 0, 1, 1));
        send_a(8'hFF, 1'b0);
        qa.push_back(mk(0, 1, 1, 1));
        send_a(8'h00, 1'b0);
        qb.push_back(mk(0, 0, 1, 1));
        send_b(8'hFF, 1'b0);
        qc.push_back(mk(0, 1, 1, 1));
        send_c(5'b00000, 1'b1);
        wait_empty();

        // Backpressure on first beat; in_valid pulses during EMIT must be ignored
        ifa.out_ready = 1'b0;
        qa.push_back(mk(4, 0, 0, 2));
        qa.push_back(mk(3, 0, 1, 2));
        send_a(8'b0001_1000, 1'b1);
        for (int i = 0; i < 3; i++) begin
            ifa.in_vec = 8'hFF; ifa.in_scan = 1'b1; ifa.in_valid = 1'b1;
            check("t4_emit_in_ready", int'(ifa.in_ready), 0);
            @(posedge clk); #1;
        end
        ifa.in_valid  = 1'b0;
        ifa.out_ready = 1'b1;
        wait_empty();

        // Reset mid-scan after the third beat
        for (int i = 7; i >= 0; i--) qa.push_back(mk(i, 0, (i == 0) ? 1 : 0, 8));
        base = beats_a;
        send_a(8'hFF, 1'b1);
        n = 0;
        while (beats_a < base + 3 && n < 100) begin @(negedge clk); #1; n++; end
        check("t5_three_beats", beats_a - base, 3);
        rst = 1'b1;
        qa.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        check("t5_rst_out_valid", int'(ifa.out_valid), 0);
        check("t5_rst_in_ready",  int'(ifa.in_ready),  1);
        qa.push_back(mk(0, 0, 1, 1));
        send_a(8'h01, 1'b1);
        wait_empty();
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
